credit_based_transmitter: RTL and testbench
===========================================

Name: credit_based_transmitter

Overview:
Transmit end of the credit-based link. Accepts words on a valid/ready upstream interface and forwards them as registered single-cycle valid pulses to a credit-based receiver. It tracks the receiver's free slots with a credit counter and only sends while credits remain. The counter is replenished by one-cycle credit-return pulses from the receiver.

Parameters:
WIDTH, 8, data word width in bits
CREDIT_COUNT, 4, maximum credits; equals the receiver buffer depth (>=1)
INITIAL_CREDITS, CREDIT_COUNT, counter value after reset (0..CREDIT_COUNT)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
write_data  input  WIDTH  upstream data
write_valid  input  1  upstream data valid
write_ready  output  1  transmitter can accept a word this cycle
read_data  output  WIDTH  downstream data, registered
read_valid  output  1  downstream one-cycle transfer pulse, registered
read_credit  input  1  one-cycle credit return pulse from the receiver, one credit per cycle high
credit_count  output  CLOG2(CREDIT_COUNT+1)  current credits available
credit_overflow  output  1  sticky error: credit returned while counter already at CREDIT_COUNT

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-low.
- Values on reset assertion: credit_count=INITIAL_CREDITS, read_valid=0, read_data=0, credit_overflow=0.
- write_ready = (credit_count != 0). It is driven from the registered counter only, with no combinational path from read_credit. A credit returned while the counter is 0 becomes usable the following cycle.
- Upstream transfer: send = write_valid & write_ready.
- On the send edge, read_valid<=1 and read_data<=write_data. Latency is one cycle from accepted input to the downstream pulse.
- No send: read_valid<=0 and read_data holds its last value.
- Back-to-back sends give consecutive read_valid cycles while credits last.
- Counter update per cycle:
  - send only: -1
  - read_credit only: +1
  - both: unchanged
  - neither: unchanged
- Underflow cannot occur because send requires count != 0.
- Overflow:
  - read_credit=1, no send, count==CREDIT_COUNT: count holds at CREDIT_COUNT and credit_overflow<=1.
  - credit_overflow stays set until reset.
  - A simultaneous send and credit at count==CREDIT_COUNT is legal: count is unchanged, no flag.
- Arithmetic: counter width CLOG2(CREDIT_COUNT+1) so CREDIT_COUNT itself is representable. No wrap-around is permitted.
- write_valid with write_ready=0: no state change. The upstream master must hold write_data and write_valid until ready.
- Reset mid-stream:
  - Counter returns to INITIAL_CREDITS.
  - Any pending read_valid is dropped.
  - The receiver must be reset in the same domain event.
- The transmitter only updates state on accepted transfers and credit pulses, so X on write_data with write_valid=0 must not propagate into the counter.

Test Plan:
- Reset with CREDIT_COUNT=4 -> credit_count=4, write_ready=1, read_valid=0, credit_overflow=0.
- Hold write_valid=1 for 6 cycles, data 0x10..0x15, read_credit=0 -> read_valid high for 4 consecutive cycles carrying 0x10..0x13, each one cycle after acceptance. write_ready falls after the 4th send; credit_count=0; 0x14 stays held upstream.
- From count 0 with write_valid held on 0x14, pulse read_credit once -> credit_count=1 the next cycle. write_ready=1 that cycle. 0x14 is accepted, read_valid pulses the cycle after, and count returns to 0.
- With count 2, write_valid=1 and read_credit=1 for 5 cycles -> read_valid high 5 cycles and credit_count stays 2 throughout.
- At count 4, idle, pulse read_credit -> credit_count stays 4 and credit_overflow=1, still 1 ten cycles later. Assert resetn=0 -> credit_overflow=0.
- Assert resetn=0 asynchronously mid-burst at count 1 with read_valid=1 -> read_valid=0 immediately and credit_count=4. After release, normal sending resumes.

Source files
------------

// File: rtl/credit_based_transmitter_if.sv
// Bundles the upstream valid/ready channel, the downstream pulse channel, and the
// credit status of the credit-based transmit link.
interface credit_based_transmitter_if #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CREDIT_COUNT = 4
);
  localparam int unsigned CW = $clog2(CREDIT_COUNT + 1);

  logic [WIDTH-1:0] write_data;
  logic             write_valid;
  logic             write_ready;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             read_credit;
  logic [CW-1:0]    credit_count;
  logic             credit_overflow;

  modport master (
    output write_data, write_valid, read_credit,
    input  write_ready, read_data, read_valid, credit_count, credit_overflow
  );

  modport slave (
    input  write_data, write_valid, read_credit,
    output write_ready, read_data, read_valid, credit_count, credit_overflow
  );
endinterface

// File: rtl/credit_based_transmitter.sv
// Transmit end of a credit-based link: forwards accepted words as registered
// one-cycle pulses and only sends while the receiver has free slots.
module credit_based_transmitter #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned CREDIT_COUNT    = 4,
  parameter int unsigned INITIAL_CREDITS = CREDIT_COUNT
) (
  input  logic                       clock,
  input  logic                       resetn,
  credit_based_transmitter_if.slave  bus
);
  localparam int unsigned   CW        = $clog2(CREDIT_COUNT + 1);
  localparam logic [CW-1:0] MAX_CRED  = CW'(CREDIT_COUNT);
  localparam logic [CW-1:0] INIT_CRED = CW'(INITIAL_CREDITS);

  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_overflow;
  logic             w_ready;
  logic             w_send;

  // Ready depends only on the registered count, so a returned credit is usable next cycle.
  assign w_ready = (r_count != '0);
  assign w_send  = bus.write_valid & w_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count    <= INIT_CRED;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= w_send;
      if (w_send) begin
        r_data <= bus.write_data;
      end
      if (w_send && !bus.read_credit) begin
        r_count <= r_count - CW'(1);
      end else if (bus.read_credit && !w_send) begin
        if (r_count == MAX_CRED) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign bus.write_ready     = w_ready;
  assign bus.read_valid      = r_valid;
  assign bus.read_data       = r_data;
  assign bus.credit_count    = r_count;
  assign bus.credit_overflow = r_overflow;
endmodule

// File: tb/tb_credit_based_transmitter.sv
// Self-checking bench for credit_based_transmitter (WIDTH=8, CREDIT_COUNT=4).
module tb_credit_based_transmitter;
  logic clk;
  logic rst_n;

  credit_based_transmitter_if #(.WIDTH(8), .CREDIT_COUNT(4)) bus ();

  credit_based_transmitter #(
    .WIDTH(8),
    .CREDIT_COUNT(4),
    .INITIAL_CREDITS(4)
  ) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rc;
    logic       rv;
    logic [7:0] rd;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sbq[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] prev_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), wait for the next negedge,
  // then match any downstream pulse against the scoreboard.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rc, input logic exp_ready);
    logic [7:0] e;
    bus.write_valid = wv;
    bus.write_data  = wd;
    bus.read_credit = rc;
    if (wv && exp_ready) sbq.push_back(wd);
    @(negedge clk);
    if (bus.read_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", {24'd0, bus.read_data}, {24'd0, e});
      end
    end
    chk("sb_latency_pending", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    // Send burst until credits run out, then hold 0x14 upstream.
    vecs.push_back('{1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 3'd3, 1'b0});
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0});
    vecs.push_back('{1'b1, 8'h12, 1'b0, 1'b1, 8'h12, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 8'h13, 1'b0, 1'b1, 8'h13, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 8'h14, 1'b0, 1'b0, 8'h13, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 8'h14, 1'b0, 1'b0, 8'h13, 3'd0, 1'b0});
    // Single credit return at zero: usable only on the following cycle.
    vecs.push_back('{1'b1, 8'h14, 1'b1, 1'b0, 8'h13, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 8'h14, 1'b0, 1'b1, 8'h14, 3'd0, 1'b0});
    // Idle with undriven data, replenish to 2.
    vecs.push_back('{1'b0, 8'hxx, 1'b1, 1'b0, 8'h14, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 8'hxx, 1'b1, 1'b0, 8'h14, 3'd2, 1'b0});
    // Simultaneous send and credit: count stays at 2.
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b1, 8'(8'h20 + i), 1'b1, 1'b1, 8'(8'h20 + i), 3'd2, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h24, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h24, 3'd4, 1'b0});
    // At max: send+credit is legal, credit alone overflows.
    vecs.push_back('{1'b1, 8'h30, 1'b1, 1'b1, 8'h30, 3'd4, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 3'd4, 1'b1});

    bus.write_valid = 1'b0;
    bus.write_data  = 8'h00;
    bus.read_credit = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_count", {29'd0, bus.credit_count}, 32'd4);
    chk("reset_ready", {31'd0, bus.write_ready}, 32'd1);
    chk("reset_rvalid", {31'd0, bus.read_valid}, 32'd0);
    chk("reset_rdata", {24'd0, bus.read_data}, 32'd0);
    chk("reset_ovf", {31'd0, bus.credit_overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    prev_cnt = 3'd4;
    foreach (vecs[i]) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].rc, prev_cnt != 3'd0);
      chk($sformatf("v%0d_rvalid", i), {31'd0, bus.read_valid}, {31'd0, vecs[i].rv});
      chk($sformatf("v%0d_rdata", i), {24'd0, bus.read_data}, {24'd0, vecs[i].rd});
      chk($sformatf("v%0d_count", i), {29'd0, bus.credit_count}, {29'd0, vecs[i].cnt});
      chk($sformatf("v%0d_ready", i), {31'd0, bus.write_ready}, {31'd0, vecs[i].cnt != 3'd0});
      chk($sformatf("v%0d_ovf", i), {31'd0, bus.credit_overflow}, {31'd0, vecs[i].ovf});
      prev_cnt = vecs[i].cnt;
    end

    // Overflow flag is sticky while idle.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_sticky", {31'd0, bus.credit_overflow}, 32'd1);
      chk("ovf_count_hold", {29'd0, bus.credit_count}, 32'd4);
    end
    rst_n = 1'b0;
    #1;
    chk("ovf_cleared_by_reset", {31'd0, bus.credit_overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Burst down to one credit, then reset asynchronously while a pulse is out.
    step(1'b1, 8'h40, 1'b0, 1'b1);
    step(1'b1, 8'h41, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b1);
    chk("burst_count", {29'd0, bus.credit_count}, 32'd1);
    chk("burst_rvalid", {31'd0, bus.read_valid}, 32'd1);
    bus.write_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", {31'd0, bus.read_valid}, 32'd0);
    chk("async_rst_count", {29'd0, bus.credit_count}, 32'd4);
    chk("async_rst_rdata", {24'd0, bus.read_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 8'h50, 1'b0, 1'b1);
    chk("resume_rvalid", {31'd0, bus.read_valid}, 32'd1);
    chk("resume_rdata", {24'd0, bus.read_data}, 32'h50);
    chk("resume_count", {29'd0, bus.credit_count}, 32'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("resume_idle_rvalid", {31'd0, bus.read_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
